// File: rtl/matrix_scan_display.sv
// Row-multiplexed LED matrix driver with an internal frame buffer.
// The game logic is granted one update cycle every frames_per_update refresh frames.
module matrix_scan_display #(
    parameter int gs                = 8,
    parameter int row_cycles        = 16,
    parameter int frames_per_update = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [gs*gs-1:0]     matrix_i,
    input  logic                 d_act_i,
    output logic                 e_act_o,
    output logic [gs-1:0]        row_o,
    output logic [gs-1:0]        col_o,
    output logic                 frame_o
);

    localparam int CW = (row_cycles > 1)        ? $clog2(row_cycles)        : 1;
    localparam int RW = (gs > 1)                ? $clog2(gs)                : 1;
    localparam int FW = (frames_per_update > 1) ? $clog2(frames_per_update) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(row_cycles - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(gs - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(frames_per_update - 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cyc_cnt;
    logic [CW-1:0]   w_cyc_next;
    logic [RW-1:0]   r_row_cnt;
    logic [RW-1:0]   w_row_next;
    logic [FW-1:0]   r_frame_cnt;
    logic [FW-1:0]   w_frm_cnt_next;

    logic [gs*gs-1:0] r_fb;

    logic [gs-1:0]   r_row;
    logic [gs-1:0]   r_col;
    logic            r_e_act;
    logic            r_frame;

    logic [gs-1:0]   w_row_dec;
    logic [gs-1:0]   w_pix;
    logic [gs-1:0]   w_fb_col [gs];
    logic            w_drive;
    logic [gs-1:0]   w_row_out;
    logic [gs-1:0]   w_col_out;
    logic            w_e_act_next;
    logic            w_frame_o_next;

    // State and counter register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= SCAN;
            r_cyc_cnt   <= '0;
            r_row_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cyc_cnt   <= w_cyc_next;
            r_row_cnt   <= w_row_next;
            r_frame_cnt <= w_frm_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cyc_next     = r_cyc_cnt;
        w_row_next     = r_row_cnt;
        w_frm_cnt_next = r_frame_cnt;
        case (r_state)
            SCAN: begin
                if (r_cyc_cnt == CYC_LAST) begin
                    w_cyc_next = '0;
                    if (r_row_cnt == ROW_LAST) begin
                        w_row_next = '0;
                        if (r_frame_cnt == FRM_LAST) begin
                            w_frm_cnt_next = '0;
                            w_state_next   = REQ;
                        end else begin
                            w_frm_cnt_next = r_frame_cnt + FW'(1);
                        end
                    end else begin
                        w_row_next = r_row_cnt + RW'(1);
                    end
                end else begin
                    w_cyc_next = r_cyc_cnt + CW'(1);
                end
            end
            REQ: begin
                w_state_next = LATCH;
            end
            LATCH: begin
                w_state_next   = SCAN;
                w_cyc_next     = '0;
                w_row_next     = '0;
                w_frm_cnt_next = '0;
            end
            default: begin
                w_state_next   = SCAN;
                w_cyc_next     = '0;
                w_row_next     = '0;
                w_frm_cnt_next = '0;
            end
        endcase
    end

    // Frame buffer only changes in LATCH, so a scan never shows a torn image
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_fb <= '0;
        end else if (r_state == LATCH && d_act_i) begin
            r_fb <= matrix_i;
        end
    end

    generate
        for (genvar gi = 0; gi < gs; gi++) begin : g_col
            assign w_row_dec[gi] = (w_row_next == RW'(gi));
            assign w_fb_col[gi]  = r_fb[gi*gs +: gs];
            assign w_pix[gi]     = w_fb_col[gi][w_row_next];
        end
    endgenerate

    // Outputs are registered from next-state values so they line up with the counters
    assign w_drive        = (w_state_next == SCAN) && (w_cyc_next != '0);
    assign w_row_out      = w_drive ? w_row_dec : '0;
    assign w_col_out      = w_drive ? ~w_pix : '1;
    assign w_e_act_next   = (w_state_next == REQ);
    assign w_frame_o_next = (w_state_next == SCAN) && (w_cyc_next == CYC_LAST)
                            && (w_row_next == ROW_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_row   <= '0;
            r_col   <= '1;
            r_e_act <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_row   <= w_row_out;
            r_col   <= w_col_out;
            r_e_act <= w_e_act_next;
            r_frame <= w_frame_o_next;
        end
    end

    assign row_o   = r_row;
    assign col_o   = r_col;
    assign e_act_o = r_e_act;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_matrix_scan_display.sv
// Directed bench for matrix_scan_display: boot timing, captures, hold, toggling and resets.
module tb_matrix_scan_display;

    localparam int GS  = 8;
    localparam int RC  = 16;
    localparam int FPU = 4;

    localparam logic [63:0] DIAG  = 64'h8040201008040201;
    localparam logic [63:0] BIRD4 = 64'h0000000000000010;
    localparam logic [63:0] BIRD5 = 64'h0000000000000020;

    logic           clk_i;
    logic           reset_ni;
    logic [63:0]    matrix_i;
    logic           d_act_i;
    logic           e_act_o;
    logic [7:0]     row_o;
    logic [7:0]     col_o;
    logic           frame_o;

    int n_checks;
    int n_fail;

    matrix_scan_display #(
        .gs(GS),
        .row_cycles(RC),
        .frames_per_update(FPU)
    ) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .matrix_i(matrix_i),
        .d_act_i(d_act_i),
        .e_act_o(e_act_o),
        .row_o(row_o),
        .col_o(col_o),
        .frame_o(frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [7:0] exp_col(input logic [63:0] fb, input int row);
        logic [7:0] r;
        for (int c = 0; c < 8; c++) r[c] = ~fb[c*8 + row];
        return r;
    endfunction

    // Runs positions 1..stop_at of an update period; position 0 is SCAN cyc 0.
    task automatic run_period(input string tag, input logic [63:0] efb, input int stop_at,
                              input logic [63:0] latch_val, input logic latch_d,
                              input bit toggle, input int spot_pos, input logic [7:0] spot_col);
        int bad_row, bad_col, bad_frame, bad_eact;
        logic [7:0] er, ec;
        logic ef, ee;
        int cyc, row;
        bad_row = 0; bad_col = 0; bad_frame = 0; bad_eact = 0;
        for (int p = 1; p <= stop_at; p++) begin
            @(posedge clk_i);
            #1;
            if (p < 512) begin
                cyc = p % RC;
                row = (p / RC) % GS;
                if (cyc == 0) begin
                    er = 8'h00;
                    ec = 8'hFF;
                end else begin
                    er = 8'(1 << row);
                    ec = exp_col(efb, row);
                end
            end else begin
                er = 8'h00;
                ec = 8'hFF;
            end
            ef = (p < 512) && ((p % 128) == 127);
            ee = (p == 512);
            if (row_o !== er)   bad_row++;
            if (col_o !== ec)   bad_col++;
            if (frame_o !== ef) bad_frame++;
            if (e_act_o !== ee) bad_eact++;
            if (p == spot_pos) check({tag, "_spot"}, col_o, spot_col);
            if (p == 512) begin
                matrix_i = latch_val;
                d_act_i  = latch_d;
            end else if (toggle && p != 513) begin
                matrix_i = {$urandom, $urandom};
                d_act_i  = 1'($urandom_range(0, 1));
            end
        end
        check({tag, "_row_bad_cycles"},   bad_row,   0);
        check({tag, "_col_bad_cycles"},   bad_col,   0);
        check({tag, "_frame_bad_cycles"}, bad_frame, 0);
        check({tag, "_eact_bad_cycles"},  bad_eact,  0);
    endtask

    task automatic reset_pulse(input string tag);
        reset_ni = 1'b0;
        #1;
        check({tag, "_async_row"},   row_o,   8'h00);
        check({tag, "_async_col"},   col_o,   8'hFF);
        check({tag, "_async_eact"},  e_act_o, 1'b0);
        check({tag, "_async_frame"}, frame_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check({tag, "_hold_eact"}, e_act_o, 1'b0);
        check({tag, "_hold_row"},  row_o,   8'h00);
        reset_ni = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_ni = 1'b0;
        matrix_i = DIAG;
        d_act_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_row",   row_o,   8'h00);
        check("reset_col",   col_o,   8'hFF);
        check("reset_eact",  e_act_o, 1'b0);
        check("reset_frame", frame_o, 1'b0);
        reset_ni = 1'b1;

        // Empty buffer for the first period; diagonal captured at its LATCH
        run_period("boot",  64'h0, 514, DIAG,  1'b1, 1'b0, 1,  8'hFF);
        run_period("diag",  DIAG,  514, BIRD4, 1'b1, 1'b0, 53, 8'hF7);
        run_period("bird4", BIRD4, 514, BIRD5, 1'b1, 1'b0, 65, 8'hFE);
        // d_act_i low with a different matrix: buffer must hold
        run_period("bird5", BIRD5, 514, 64'hDEADBEEF01234567, 1'b0, 1'b0, 82, 8'hFE);
        run_period("hold",  BIRD5, 514, DIAG,  1'b1, 1'b0, 82, 8'hFE);
        run_period("toggle", DIAG, 514, BIRD4, 1'b1, 1'b1, 53, 8'hF7);

        // Reset during REQ
        run_period("pre_req", BIRD4, 511, BIRD4, 1'b1, 1'b0, 65, 8'hFE);
        @(posedge clk_i);
        #1;
        check("req_eact", e_act_o, 1'b1);
        reset_pulse("rst_req");
        run_period("after_rst1", 64'h0, 514, BIRD5, 1'b1, 1'b0, 65, 8'hFF);

        // Reset in the middle of row 5
        run_period("pre_mid5", BIRD5, 87, BIRD5, 1'b1, 1'b0, 82, 8'hFE);
        check("mid5_row", row_o, 8'h20);
        check("mid5_col", col_o, 8'hFE);
        reset_pulse("rst_mid5");
        run_period("after_rst2", 64'h0, 514, 64'h0, 1'b0, 1'b0, 82, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
